hall_input_conditioner: RTL
===========================

HALL_INPUT_CONDITIONER -- requirements
Module: hall_input_conditioner

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth, minimum 2.
REQ-002 SHALL have parameter FILTER_CYCLES, default 16: stable cycles required to accept a new hall code, minimum 1.
REQ-003 SHALL have parameter PERIOD_W, default 24: width of period counter/output.
REQ-004 SHALL have port pclk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port preset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port hall_raw  in  hall_states_t (3)  unsynchronised sensor pins.
REQ-007 SHALL have port hall_values  out  hall_states_t (3)  filtered code, feeds the bldc peripheral.
REQ-008 SHALL have port edge_strobe  out  1  one-cycle pulse on every accepted code change.
REQ-009 SHALL have port period  out  PERIOD_W  pclk cycles between the last two accepted valid edges.
REQ-010 SHALL have port period_valid  out  1  one-cycle pulse when period is updated with a trustworthy value.
REQ-011 SHALL have port hall_error  out  1  level; filtered code is 3'b000 or 3'b111.
REQ-012 SHALL have port stall  out  1  level; no edge within 2^PERIOD_W-1 cycles.
REQ-013 SHALL have port seq_error  out  1  one-cycle pulse on a non-adjacent commutation step.

Function
REQ-014 SHALL pass each hall_raw bit through SYNC_STAGES flops before any other use.
REQ-015 SHALL accept the synchronised 3-bit vector into hall_values only after it has differed from hall_values and held one identical value for FILTER_CYCLES consecutive cycles; any change restarts the count.
REQ-016 SHALL give a raw-change-to-hall_values latency of exactly SYNC_STAGES+FILTER_CYCLES cycles; edge_strobe SHALL assert in the same cycle hall_values updates.
REQ-017 SHALL run a free counter, cleared on each accepted edge, incrementing each cycle, saturating at 2^PERIOD_W-1.
REQ-018 SHALL on an accepted valid edge in state RUN load period with counter+1 (two edges N cycles apart give N) and pulse period_valid.
REQ-019 SHALL implement states IDLE, RUN, STALL: IDLE->RUN on accepted valid code (no period_valid); RUN->STALL when counter saturates; STALL->RUN on accepted valid code (no period_valid); any state->IDLE on accepted invalid code.
REQ-020 SHALL drive stall high exactly while in STALL; SHALL hold period unchanged outside period_valid cycles.
REQ-021 SHALL set hall_error while hall_values is 000 or 111 and clear it on the edge accepting a valid code; invalid codes SHALL still produce edge_strobe.
REQ-022 SHALL treat valid forward sequence as 001,011,010,110,100,101 (cyclic); reverse is the same order backwards.

Reset
REQ-023 SHALL on preset_n low, immediately and regardless of filter progress: clear synchronisers, filter count and period counter; hall_values=000, period=0, state IDLE, all pulses and stall low, hall_error low.
REQ-024 SHALL begin filtering on the first clock after preset_n deasserts; the initial 000 SHALL NOT raise hall_error until a code is accepted.

Configuration
REQ-025 SHALL, with HALL_SEQ_CHECK_EN defined, pulse seq_error and suppress period_valid (counter still cleared) when, in RUN, an accepted valid code is neither forward nor reverse neighbour of the previous code.
REQ-026 SHALL, without HALL_SEQ_CHECK_EN, tie seq_error to 0 and apply REQ-018 to every valid edge in RUN.

Structure
REQ-027 SHALL place hall_states_t, the six-entry sequence table, and the state enum in the shared bldc package.
REQ-028 SHALL implement the synchroniser+stability filter as one sub-module hall_glitch_filter; state machine and period logic in the top.

Verification (SYNC_STAGES=2, FILTER_CYCLES=4, PERIOD_W=8)
REQ-029 SHALL check: release reset with hall_raw=001 -> hall_values=001 and edge_strobe 6 cycles later, period_valid 0, state RUN.
REQ-030 SHALL check: from 001, raw=011 for 3 cycles then 001 -> no edge_strobe, hall_values stays 001.
REQ-031 SHALL check: 001->011->010 with accepted edges 100 cycles apart -> period=100, one period_valid pulse on second edge.
REQ-032 SHALL check: raw=111 -> hall_error=1, state IDLE; then raw=001 -> hall_error=0, no period_valid; next edge yields period_valid.
REQ-033 SHALL check: no edge for 255 cycles -> stall=1; next edge -> stall=0 without period_valid; following edge 50 cycles later -> period=50.
REQ-034 SHALL check: in RUN 001->110 -> seq_error pulse and no period_valid with HALL_SEQ_CHECK_EN; without it, seq_error=0 and period_valid pulses.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared BLDC definitions.
//   hall_states_t  : 3-bit hall sensor code (bit order as wired to the pins)
//   hall_fsm_t     : hall conditioner state machine encoding
//   HALL_SEQ       : six valid codes in forward commutation order
//   hall_is_valid  : 1 when a code is neither 000 nor 111
//   hall_adjacent  : 1 when nxt is the forward or reverse neighbour of prev
package bldc_pkg;

   typedef logic [2:0] hall_states_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } hall_fsm_t;

   localparam hall_states_t HALL_SEQ [6] = '{3'b001, 3'b011, 3'b010,
                                             3'b110, 3'b100, 3'b101};

   function automatic logic hall_is_valid(input hall_states_t code);
      return (code != 3'b000) && (code != 3'b111);
   endfunction

   function automatic logic hall_adjacent(input hall_states_t prev,
                                          input hall_states_t nxt);
      logic adj;
      adj = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (HALL_SEQ[3'(i)] == prev) begin
            // (i+5)%6 is the previous entry, i.e. one step in reverse
            if ((HALL_SEQ[3'((i + 1) % 6)] == nxt) ||
                (HALL_SEQ[3'((i + 5) % 6)] == nxt)) begin
               adj = 1'b1;
            end
         end
      end
      return adj;
   endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// Hall input synchroniser and stability filter.
// Each raw bit passes through SYNC_STAGES flops; the synchronised vector is
// accepted into hall_o only after it has differed from hall_o and held one
// value for FILTER_CYCLES consecutive cycles.
// Ports:
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   raw_i     : unsynchronised hall pins
//   hall_o    : filtered code (registered)
//   strobe_o  : one-cycle pulse in the cycle hall_o takes a new code
//   accept_o  : combinational, high in the cycle before hall_o updates
//   code_o    : code about to be accepted (valid while accept_o is high)
module hall_glitch_filter
   import bldc_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  hall_states_t raw_i,
   output hall_states_t hall_o,
   output logic         strobe_o,
   output logic         accept_o,
   output hall_states_t code_o
);

   localparam int              CNT_W  = $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0] FILT_N = CNT_W'(FILTER_CYCLES);

   hall_states_t     sync_q [SYNC_STAGES];
   hall_states_t     sync_s;
   hall_states_t     cand_q, cand_d;
   hall_states_t     hall_q, hall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             strobe_q, strobe_d;
   logic             accept;

   always_comb begin
      sync_s   = sync_q[SYNC_STAGES-1];
      // A value differing from the tracked candidate restarts the count at 1
      cnt_inc  = (sync_s == cand_q) ? cnt_q + 1'b1 : CNT_W'(1);
      accept   = (sync_s != hall_q) && (cnt_inc >= FILT_N);
      cand_d   = sync_s;
      cnt_d    = cnt_inc;
      hall_d   = hall_q;
      strobe_d = 1'b0;
      if (sync_s == hall_q) begin
         cnt_d = '0;
      end else if (accept) begin
         hall_d   = sync_s;
         strobe_d = 1'b1;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         cand_q   <= '0;
         hall_q   <= '0;
         cnt_q    <= '0;
         strobe_q <= 1'b0;
      end else begin
         sync_q[0] <= raw_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         cand_q   <= cand_d;
         hall_q   <= hall_d;
         cnt_q    <= cnt_d;
         strobe_q <= strobe_d;
      end
   end

   assign hall_o   = hall_q;
   assign strobe_o = strobe_q;
   assign accept_o = accept;
   assign code_o   = sync_s;

endmodule

// File: rtl/hall_input_conditioner.sv
// Hall sensor input conditioner: glitch filter, commutation period
// measurement, stall detection and invalid-code flagging.
// Optional feature: define HALL_SEQ_CHECK_EN to flag non-adjacent
// commutation steps on seq_error and withhold their period_valid.
// Ports:
//   pclk         : sole clock, rising edge
//   preset_n     : asynchronous active-low reset
//   hall_raw     : unsynchronised sensor pins
//   hall_values  : filtered code for the bldc peripheral
//   edge_strobe  : one-cycle pulse on every accepted code change
//   period       : pclk cycles between the last two accepted valid edges
//   period_valid : one-cycle pulse when period is updated
//   hall_error   : level, filtered code is 000 or 111
//   stall        : level, no edge for 2^PERIOD_W-1 cycles
//   seq_error    : one-cycle pulse on a non-adjacent step
module hall_input_conditioner
   import bldc_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 16,
   parameter int PERIOD_W      = 24
) (
   input  logic                pclk,
   input  logic                preset_n,
   input  hall_states_t        hall_raw,
   output hall_states_t        hall_values,
   output logic                edge_strobe,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                hall_error,
   output logic                stall,
   output logic                seq_error
);

   localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

   logic                accept;
   hall_states_t        new_code;
   logic                step_ok;
   hall_fsm_t           state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                pv_q, pv_d;
   logic                herr_q, herr_d;

   hall_glitch_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter (
      .clk_i    (pclk),
      .rst_ni   (preset_n),
      .raw_i    (hall_raw),
      .hall_o   (hall_values),
      .strobe_o (edge_strobe),
      .accept_o (accept),
      .code_o   (new_code)
   );

`ifdef HALL_SEQ_CHECK_EN
   logic seq_q;

   // hall_values still holds the previous code while accept is high
   assign step_ok = hall_adjacent(hall_values, new_code);

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) seq_q <= 1'b0;
      else           seq_q <= accept && hall_is_valid(new_code) &&
                              (state_q == RUN) && !step_ok;
   end

   assign seq_error = seq_q;
`else
   assign step_ok   = 1'b1;
   assign seq_error = 1'b0;
`endif

   always_comb begin
      cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      state_d  = state_q;
      period_d = period_q;
      pv_d     = 1'b0;
      herr_d   = herr_q;
      if (accept) begin
         cnt_d  = '0;
         herr_d = !hall_is_valid(new_code);
         if (!hall_is_valid(new_code)) begin
            state_d = IDLE;
         end else begin
            state_d = RUN;
            // Only a RUN->RUN edge measures a full, unsaturated interval;
            // counter+1 counts the edge cycle itself
            if ((state_q == RUN) && step_ok) begin
               period_d = cnt_q + 1'b1;
               pv_d     = 1'b1;
            end
         end
      end else if ((state_q == RUN) && (cnt_q >= CNT_MAX - 1'b1)) begin
         // Counter reaches its saturation value on this edge
         state_d = STALL;
      end
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
         pv_q     <= 1'b0;
         herr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         pv_q     <= pv_d;
         herr_q   <= herr_d;
      end
   end

   assign period       = period_q;
   assign period_valid = pv_q;
   assign hall_error   = herr_q;
   assign stall        = (state_q == STALL);

endmodule
